// File: rtl/ex_stage_pipe.sv
// Registered valid/ready execute stage: operand forwarding, ALU, branch target and zero flag.
// Define EX_MULDIV_EN to build the iterative RV32M multiply/divide unit (RUN/DONE states, busy).
module ex_stage_pipe #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_WORDS = 1024,
  parameter int ADDR_SIZE = $clog2(NUM_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_SIZE-1:0] pc,
  input  logic [WORD_SIZE-1:0] data1,
  input  logic [WORD_SIZE-1:0] data2,
  input  logic [WORD_SIZE-1:0] mem_forward1,
  input  logic [WORD_SIZE-1:0] mem_forward2,
  input  logic [WORD_SIZE-1:0] wb_forward1,
  input  logic [WORD_SIZE-1:0] wb_forward2,
  input  logic [1:0]           sel_forward1,
  input  logic [1:0]           sel_forward2,
  input  logic [WORD_SIZE-1:0] immd,
  input  logic [3:0]           alu_op,
  input  logic                 alu_src,
  input  logic                 branch,
  input  logic                 jump,
  input  logic                 is_muldiv,
  input  logic [2:0]           muldiv_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] result,
  output logic [WORD_SIZE-1:0] write_data,
  output logic                 zero,
  output logic [ADDR_SIZE-1:0] branch_target,
  output logic                 busy
);
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_LUI = 4'd10;
  localparam int SHW = $clog2(WORD_SIZE);

  function automatic logic [WORD_SIZE-1:0] fwd(input logic [1:0] sel,
      input logic [WORD_SIZE-1:0] r, input logic [WORD_SIZE-1:0] m, input logic [WORD_SIZE-1:0] w);
    case (sel)
      2'd1:    return m;
      2'd2:    return w;
      default: return r;
    endcase
  endfunction

  logic [WORD_SIZE-1:0] op_a, src2, op_b, alu_res;
  logic                 alu_zero, accept;
  logic [ADDR_SIZE-1:0] pc_m4, bt_calc;

  logic                 out_valid_q, out_valid_d, zero_q, zero_d;
  logic [WORD_SIZE-1:0] result_q, result_d, wdata_q, wdata_d;
  logic [ADDR_SIZE-1:0] bt_q, bt_d;

  always_comb begin
    op_a = fwd(sel_forward1, data1, mem_forward1, wb_forward1);
    src2 = fwd(sel_forward2, data2, mem_forward2, wb_forward2);
    op_b = alu_src ? immd : src2;
  end

  always_comb begin
    case (alu_op)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SLL:  alu_res = op_a << op_b[SHW-1:0];
      ALU_SRL:  alu_res = op_a >> op_b[SHW-1:0];
      ALU_SRA:  alu_res = WORD_SIZE'($signed(op_a) >>> op_b[SHW-1:0]);
      ALU_SLT:  alu_res = {{(WORD_SIZE-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(WORD_SIZE-1){1'b0}}, op_a < op_b};
      ALU_LUI:  alu_res = op_b;
      default:  alu_res = '0;
    endcase
    alu_zero = (alu_op == ALU_SLT || alu_op == ALU_SLTU) ? alu_res[0] : (alu_res == '0);
  end

  assign pc_m4   = pc - ADDR_SIZE'(4);
  assign bt_calc = (branch || jump) ? pc_m4 + {immd[ADDR_SIZE-3:0], 2'b00} : pc_m4;
  assign accept  = in_valid && in_ready;

  assign out_valid     = out_valid_q;
  assign result        = result_q;
  assign write_data    = wdata_q;
  assign zero          = zero_q;
  assign branch_target = bt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      wdata_q     <= '0;
      zero_q      <= 1'b0;
      bt_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      wdata_q     <= wdata_d;
      zero_q      <= zero_d;
      bt_q        <= bt_d;
    end
  end

`ifdef EX_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  localparam int CW = $clog2(WORD_SIZE + 1);

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]   acc_q, acc_d, lo_q, lo_d, opnd_q, opnd_d, wd_hold_q, wd_hold_d;
  logic [2:0]             mop_q, mop_d;
  logic                   neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [ADDR_SIZE-1:0]   pc_hold_q, pc_hold_d;
  logic                   a_sgn, b_sgn, a_neg, b_neg;
  logic [WORD_SIZE-1:0]   mag_a, mag_b, quo_f, rem_f, md_res;
  logic [2*WORD_SIZE-1:0] prod, prod_f;
  logic [WORD_SIZE:0]     mul_sum, div_sh;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready) && !flush && !rst;
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    a_sgn  = !(muldiv_op == 3'b011 || (muldiv_op[2] && muldiv_op[0]));
    b_sgn  = a_sgn && (muldiv_op != 3'b010);
    a_neg  = a_sgn && op_a[WORD_SIZE-1];
    b_neg  = b_sgn && op_b[WORD_SIZE-1];
    mag_a  = a_neg ? -op_a : op_a;
    mag_b  = b_neg ? -op_b : op_b;
    // Multiply keeps the multiplicand in opnd and shifts the multiplier out of lo;
    // divide keeps the divisor in opnd and shifts the quotient into lo.
    mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_sh  = {acc_q, lo_q[WORD_SIZE-1]};
    prod    = {acc_q, lo_q};
    prod_f  = (neg_a_q ^ neg_b_q) ? -prod : prod;
    quo_f   = ((neg_a_q ^ neg_b_q) && (opnd_q != '0)) ? -lo_q : lo_q;
    rem_f   = neg_a_q ? -acc_q : acc_q;
    if (mop_q[2])                md_res = mop_q[1] ? rem_f : quo_f;
    else if (mop_q[1:0] == 2'b00) md_res = prod_f[WORD_SIZE-1:0];
    else                         md_res = prod_f[2*WORD_SIZE-1:WORD_SIZE];
  end

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;    acc_d = acc_q;    lo_d = lo_q;
    opnd_d = opnd_q;    mop_d = mop_q;    neg_a_d = neg_a_q; neg_b_d = neg_b_q;
    pc_hold_d = pc_hold_q; wd_hold_d = wd_hold_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d = result_q; wdata_d = wdata_q; zero_d = zero_q; bt_d = bt_q;
    case (state_q)
      S_IDLE: begin
        if (accept && is_muldiv) begin
          state_d   = S_RUN;
          cnt_d     = CW'(WORD_SIZE);
          acc_d     = '0;
          lo_d      = muldiv_op[2] ? mag_a : mag_b;
          opnd_d    = muldiv_op[2] ? mag_b : mag_a;
          mop_d     = muldiv_op;
          neg_a_d   = a_neg;
          neg_b_d   = b_neg;
          pc_hold_d = pc_m4;
          wd_hold_d = src2;
        end else if (accept) begin
          out_valid_d = 1'b1;
          result_d    = alu_res;
          wdata_d     = src2;
          zero_d      = alu_zero;
          bt_d        = bt_calc;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (mop_q[2]) begin
          if (div_sh >= {1'b0, opnd_q}) begin
            acc_d = WORD_SIZE'(div_sh - {1'b0, opnd_q});
            lo_d  = {lo_q[WORD_SIZE-2:0], 1'b1};
          end else begin
            acc_d = div_sh[WORD_SIZE-1:0];
            lo_d  = {lo_q[WORD_SIZE-2:0], 1'b0};
          end
        end else begin
          acc_d = mul_sum[WORD_SIZE:1];
          lo_d  = {mul_sum[0], lo_q[WORD_SIZE-1:1]};
        end
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b1;
        result_d    = md_res;
        wdata_d     = wd_hold_q;
        zero_d      = (md_res == '0);
        bt_d        = pc_hold_q;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;  cnt_q <= '0;    acc_q <= '0;      lo_q <= '0;
      opnd_q <= '0;       mop_q <= '0;    neg_a_q <= 1'b0;  neg_b_q <= 1'b0;
      pc_hold_q <= '0;    wd_hold_q <= '0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; acc_q <= acc_d;     lo_q <= lo_d;
      opnd_q <= opnd_d;   mop_q <= mop_d; neg_a_q <= neg_a_d; neg_b_q <= neg_b_d;
      pc_hold_q <= pc_hold_d; wd_hold_q <= wd_hold_d;
    end
  end
`else
  logic unused_muldiv;
  assign unused_muldiv = ^muldiv_op;
  assign in_ready      = (!out_valid_q || out_ready) && !flush && !rst;
  assign busy          = 1'b0;

  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    result_d = result_q; wdata_d = wdata_q; zero_d = zero_q; bt_d = bt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = is_muldiv ? '0 : alu_res;
      wdata_d     = src2;
      zero_d      = is_muldiv ? 1'b1 : alu_zero;
      bt_d        = bt_calc;
    end
    if (flush) out_valid_d = 1'b0;
  end
`endif
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Self-checking bench for ex_stage_pipe: randomized ALU traffic against an arithmetic model,
// directed/random RV32M cases (when EX_MULDIV_EN is defined), backpressure, flush and reset.
module tb_ex_stage_pipe;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [9:0]  pc, branch_target;
  logic [31:0] data1, data2, mem_forward1, mem_forward2, wb_forward1, wb_forward2, immd;
  logic [31:0] result, write_data;
  logic [1:0]  sel_forward1, sel_forward2;
  logic [3:0]  alu_op;
  logic        alu_src, branch, jump, is_muldiv;
  logic [2:0]  muldiv_op;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  ex_stage_pipe #(.WORD_SIZE(32), .NUM_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .pc(pc),
    .data1(data1), .data2(data2), .mem_forward1(mem_forward1), .mem_forward2(mem_forward2),
    .wb_forward1(wb_forward1), .wb_forward2(wb_forward2), .sel_forward1(sel_forward1),
    .sel_forward2(sel_forward2), .immd(immd), .alu_op(alu_op), .alu_src(alu_src),
    .branch(branch), .jump(jump), .is_muldiv(is_muldiv), .muldiv_op(muldiv_op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .write_data(write_data),
    .zero(zero), .branch_target(branch_target), .busy(busy));

  typedef struct {
    logic [31:0] d1, d2, mf1, mf2, wf1, wf2, imm;
    logic [1:0]  s1, s2;
    logic [3:0]  op;
    logic        src, br, jmp, md;
    logic [2:0]  mop;
    logic [9:0]  pc;
  } instr_t;

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_fwd(input logic [1:0] s, input logic [31:0] r, input logic [31:0] m, input logic [31:0] w);
    if (s == 2'd1) return m;
    if (s == 2'd2) return w;
    return r;
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return $unsigned($signed(a) >>> b[4:0]);
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [9:0] m_bt(input logic [9:0] p, input logic [31:0] imm, input logic take);
    logic [31:0] t;
    t = {22'd0, p} - 32'd4 + (take ? imm * 32'd4 : 32'd0);
    return t[9:0];
  endfunction

  function automatic logic [31:0] m_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    za = {32'd0, a};       zb = {32'd0, b};
    case (op)
      3'd0: begin p = za * zb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * zb; return p[63:32]; end
      3'd3: begin p = za * zb; return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
            else return $unsigned($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: if (b == 0) return a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
            else return $unsigned($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic void m_exp(input instr_t i, output logic [31:0] r, output logic z,
                                output logic [9:0] bt, output logic [31:0] wd);
    logic [31:0] a, s2, b;
    a  = m_fwd(i.s1, i.d1, i.mf1, i.wf1);
    s2 = m_fwd(i.s2, i.d2, i.mf2, i.wf2);
    b  = i.src ? i.imm : s2;
    r  = m_alu(i.op, a, b);
    z  = (i.op == 4'd8 || i.op == 4'd9) ? r[0] : (r == 32'd0);
    bt = m_bt(i.pc, i.imm, i.br || i.jmp);
    wd = s2;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic rand_instr(output instr_t i);
    i.d1 = $urandom; i.d2 = $urandom; i.mf1 = $urandom; i.mf2 = $urandom;
    i.wf1 = $urandom; i.wf2 = $urandom;
    i.imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64));
    i.s1 = 2'($urandom_range(0, 3)); i.s2 = 2'($urandom_range(0, 3));
    i.op = 4'($urandom_range(0, 15)); i.src = 1'($urandom_range(0, 1));
    i.br = 1'($urandom_range(0, 1)); i.jmp = 1'($urandom_range(0, 1));
    i.md = 1'b0; i.mop = 3'd0; i.pc = 10'($urandom);
  endtask

  task automatic drive(input instr_t i);
    data1 = i.d1; data2 = i.d2; mem_forward1 = i.mf1; mem_forward2 = i.mf2;
    wb_forward1 = i.wf1; wb_forward2 = i.wf2; immd = i.imm;
    sel_forward1 = i.s1; sel_forward2 = i.s2; alu_op = i.op; alu_src = i.src;
    branch = i.br; jump = i.jmp; is_muldiv = i.md; muldiv_op = i.mop; pc = i.pc;
  endtask

  task automatic issue_one(input instr_t i);
    drive(i); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    instr_t i;
    rand_instr(i); drive(i);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if ({out_valid, result, write_data, zero, branch_target, busy} !== 76'd0) begin
      n_err++; $display("FAIL reset_outputs: got ov=%b res=%h wd=%h z=%b bt=%h busy=%b want all 0",
                        out_valid, result, write_data, zero, branch_target, busy); end
    #2 rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_alu_directed;
    instr_t i;
    i = '{default: '0};
    i.d1 = 32'd5; i.imm = 32'd7; i.src = 1'b1; i.op = 4'd0; i.pc = 10'h100;
    issue_one(i);
    n_cmp++; if ({out_valid, result, zero} !== {1'b1, 32'd12, 1'b0}) begin
      n_err++; $display("FAIL add_imm: got ov=%b res=%h z=%b want ov=1 res=0000000c z=0", out_valid, result, zero); end
    i = '{default: '0};
    i.s1 = 2'd2; i.wf1 = 32'h10; i.d1 = 32'h99; i.d2 = 32'h10; i.op = 4'd1; i.pc = 10'h100;
    issue_one(i);
    n_cmp++; if ({result, zero, write_data} !== {32'd0, 1'b1, 32'h10}) begin
      n_err++; $display("FAIL fwd_sub: got res=%h z=%b wd=%h want res=0 z=1 wd=10", result, zero, write_data); end
    i = '{default: '0};
    i.pc = 10'h008; i.imm = 32'd3; i.br = 1'b1;
    issue_one(i);
    n_cmp++; if (branch_target !== 10'h010) begin n_err++; $display("FAIL branch_target: got %h want 010", branch_target); end
    i = '{default: '0};
    issue_one(i);
    n_cmp++; if (branch_target !== 10'h3FC) begin n_err++; $display("FAIL bt_wrap: got %h want 3fc", branch_target); end
  endtask

  task automatic test_back_to_back;
    instr_t i;
    logic [31:0] er, ew; logic ez; logic [9:0] eb;
    for (int k = 0; k < 40; k++) begin
      rand_instr(i); drive(i); in_valid = 1'b1; out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", k, in_ready); end
      @(posedge clk); #1;
      m_exp(i, er, ez, eb, ew);
      n_cmp++; if ({out_valid, result, zero, branch_target, write_data} !== {1'b1, er, ez, eb, ew}) begin
        n_err++; $display("FAIL b2b[%0d] op=%0d: got ov=%b res=%h z=%b bt=%h wd=%h want ov=1 res=%h z=%b bt=%h wd=%h",
                          k, i.op, out_valid, result, zero, branch_target, write_data, er, ez, eb, ew); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got ov=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure;
    instr_t i1, i2;
    logic [31:0] r1, w1, r2, w2; logic z1, z2; logic [9:0] b1, b2;
    rand_instr(i1); rand_instr(i2);
    m_exp(i1, r1, z1, b1, w1); m_exp(i2, r2, z2, b2, w2);
    drive(i1); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    drive(i2);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
      n_cmp++; if ({out_valid, result, zero, branch_target, write_data} !== {1'b1, r1, z1, b1, w1}) begin
        n_err++; $display("FAIL bp_hold[%0d]: got ov=%b res=%h want ov=1 res=%h", k, out_valid, result, r1); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, result, zero, branch_target, write_data} !== {1'b1, r2, z2, b2, w2}) begin
      n_err++; $display("FAIL bp_same_edge: got ov=%b res=%h want ov=1 res=%h", out_valid, result, r2); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got ov=%b want 0", out_valid); end
  endtask

  task automatic test_muldiv;
    logic [2:0]  t_op [12] = '{3'd1, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd0, 3'd4, 3'd6, 3'd2, 3'd4, 3'd6};
    logic [31:0] t_a  [12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'd7, 32'd7,
                               32'hFFFFFFFD, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFF9};
    logic [31:0] t_b  [12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,
                               32'd7, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0};
    logic [31:0] t_e  [12] = '{32'h0, 32'hFFFFFFFE, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'd7,
                               32'hFFFFFFEB, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    instr_t i;
    logic [31:0] exp_r;
    int cyc;
    for (int k = 0; k < 28; k++) begin
      i = '{default: '0};
      i.md = 1'b1; i.pc = 10'($urandom); i.mf1 = $urandom; i.wf2 = $urandom;
      if (k < 12) begin
        i.mop = t_op[k]; i.d1 = t_a[k]; i.d2 = t_b[k]; exp_r = t_e[k];
      end else begin
        i.mop = 3'($urandom_range(0, 7));
        i.d1 = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
        i.d2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        exp_r = m_md(i.mop, i.d1, i.d2);
      end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL md_ready[%0d]: got %b want 1", k, in_ready); end
      issue_one(i);
      is_muldiv = 1'b0;
`ifdef EX_MULDIV_EN
      n_cmp++; if ({busy, in_ready, out_valid} !== 3'b100) begin
        n_err++; $display("FAIL md_run[%0d]: got busy=%b in_ready=%b ov=%b want 1 0 0", k, busy, in_ready, out_valid); end
      cyc = 0;
      while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
      n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL md_latency[%0d]: got %0d cycles want 33", k, cyc); end
      n_cmp++; if ({result, zero, branch_target, write_data, busy} !== {exp_r, exp_r == 32'd0, m_bt(i.pc, 32'd0, 1'b0), i.d2, 1'b0}) begin
        n_err++; $display("FAIL md_result[%0d] op=%0d a=%h b=%h: got res=%h z=%b bt=%h busy=%b want res=%h z=%b bt=%h",
                          k, i.mop, i.d1, i.d2, result, zero, branch_target, busy, exp_r, exp_r == 32'd0, m_bt(i.pc, 32'd0, 1'b0)); end
`else
      cyc = 0;
      n_cmp++; if ({out_valid, result, zero, busy} !== {1'b1, 32'd0, 1'b1, 1'b0}) begin
        n_err++; $display("FAIL md_disabled[%0d]: got ov=%b res=%h z=%b busy=%b want 1 0 1 0", k, out_valid, result, zero, busy); end
`endif
    end
  endtask

  task automatic test_flush;
    instr_t i;
    int seen;
    rand_instr(i); drive(i); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_setup: got ov=%b want 1", out_valid); end
    rand_instr(i); drive(i); flush = 1'b1; out_ready = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_kill: got ov=%b want 0", out_valid); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_accept: got ov=%b want 0", out_valid); end
`ifdef EX_MULDIV_EN
    i = '{default: '0};
    i.md = 1'b1; i.mop = 3'd4; i.d1 = 32'd1000; i.d2 = 32'd7;
    issue_one(i);
    is_muldiv = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++; if ({busy, out_valid} !== 2'b00) begin n_err++; $display("FAIL flush_run: got busy=%b ov=%b want 0 0", busy, out_valid); end
    seen = 0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (out_valid) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL flush_run_no_result: got %0d valid cycles want 0", seen); end
`endif
  endtask

  task automatic test_rst_mid_run;
    instr_t i;
    int seen;
    i = '{default: '0};
    i.d1 = 32'd5; i.imm = 32'd7; i.src = 1'b1; i.pc = 10'h120; i.d2 = 32'h55;
    issue_one(i);
`ifdef EX_MULDIV_EN
    i = '{default: '0};
    i.md = 1'b1; i.mop = 3'd0; i.d1 = 32'd3; i.d2 = 32'd5;
    issue_one(i);
    is_muldiv = 1'b0;
    repeat (5) @(posedge clk);
    #1;
`endif
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({out_valid, result, write_data, zero, branch_target, busy, in_ready} !== 77'd0) begin
      n_err++; $display("FAIL rst_mid: got ov=%b res=%h wd=%h z=%b bt=%h busy=%b rdy=%b want all 0",
                        out_valid, result, write_data, zero, branch_target, busy, in_ready); end
    #2 rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (out_valid) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rst_discard: got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    test_reset;
    test_alu_directed;
    test_back_to_back;
    test_backpressure;
    test_muldiv;
    test_flush;
    test_rst_mid_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
